// File: rtl/mtr_ramp_sched.sv
// mtr_ramp_sched: slews left/right motor speed commands toward handshaked targets on a fixed tick,
// with run/stop sequencing, emergency stop and low-battery cutoff.
module mtr_ramp_sched #(
  parameter int          RAMP_DIV  = 1024,
  parameter logic [11:0] STEP      = 12'd16,
  parameter logic [11:0] SPD_LIM   = 12'd2047,
  parameter logic [11:0] VBATT_MIN = 12'h2C0,
  parameter logic [11:0] VBATT_OK  = 12'h300,
  parameter int          LOW_CNT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] tgt_lft,
  input  logic [11:0] tgt_rght,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  input  logic        go,
  input  logic        estop,
  input  logic [11:0] vbatt,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        busy,
  output logic        at_tgt,
  output logic        batt_fault
);
  localparam int CW = $clog2(RAMP_DIV);
  localparam int LW = $clog2(LOW_CNT + 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP, FAULT} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] low_q, low_d;
  logic signed [11:0] lft_q, lft_d, rght_q, rght_d, tl_q, tl_d, tr_q, tr_d;
  logic bf_q, bf_d;
  logic tick, trip, cap;

  function automatic logic signed [11:0] clamp(input logic signed [11:0] t);
    logic signed [11:0] lim;
    lim = $signed(SPD_LIM);
    return t > lim ? lim : (t < -lim ? -lim : t);
  endfunction

  // 13-bit difference so the full signed range never wraps; the final step lands exactly on target
  function automatic logic signed [11:0] step_to(input logic signed [11:0] spd,
                                                 input logic signed [11:0] tgt);
    logic signed [12:0] d, s;
    d = {tgt[11], tgt} - {spd[11], spd};
    s = {1'b0, STEP};
    return (d <= s && d >= -s) ? tgt : (d[12] ? spd - $signed(STEP) : spd + $signed(STEP));
  endfunction

  assign tgt_rdy    = state_q != FAULT;
  assign busy       = state_q != IDLE;
  assign at_tgt     = state_q == RUN && lft_q == tl_q && rght_q == tr_q;
  assign batt_fault = bf_q;
  assign lft_spd    = lft_q;
  assign rght_spd   = rght_q;

  always_comb begin
    low_d   = vbatt >= VBATT_MIN ? '0 : (low_q == LW'(LOW_CNT) ? low_q : low_q + 1'b1);
    trip    = low_d == LW'(LOW_CNT);
    tick    = cnt_q == CW'(RAMP_DIV - 1);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    cap     = tgt_vld && tgt_rdy;
    tl_d    = cap ? clamp(tgt_lft) : tl_q;
    tr_d    = cap ? clamp(tgt_rght) : tr_q;
    state_d = state_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    bf_d    = bf_q;
    if (estop || trip) begin
      state_d = FAULT;
      lft_d   = '0;
      rght_d  = '0;
      bf_d    = estop ? bf_q : 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          lft_d   = '0;
          rght_d  = '0;
          state_d = go ? RUN : IDLE;
          cnt_d   = go ? '0 : cnt_d;
        end
        RUN: begin
          lft_d   = tick ? step_to(lft_q, tl_q) : lft_q;
          rght_d  = tick ? step_to(rght_q, tr_q) : rght_q;
          state_d = go ? RUN : STOP;
        end
        STOP: begin
          lft_d   = tick ? step_to(lft_q, '0) : lft_q;
          rght_d  = tick ? step_to(rght_q, '0) : rght_q;
          state_d = go ? RUN : (lft_q == '0 && rght_q == '0 ? IDLE : STOP);
        end
        default: begin
          lft_d   = '0;
          rght_d  = '0;
          state_d = !go && vbatt >= VBATT_OK ? IDLE : FAULT;
          bf_d    = !go && vbatt >= VBATT_OK ? 1'b0 : bf_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      low_q   <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      tl_q    <= '0;
      tr_q    <= '0;
      bf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      tl_q    <= tl_d;
      tr_q    <= tr_d;
      bf_q    <= bf_d;
    end
  end
endmodule

// File: tb/tb_mtr_ramp_sched.sv
// tb_mtr_ramp_sched: directed scenarios for the ramp scheduler with hand-computed expected speeds.
module tb_mtr_ramp_sched;
  logic clk = 1'b0;
  logic rst_n, tgt_vld, tgt_rdy, go, estop, busy, at_tgt, batt_fault;
  logic signed [11:0] tgt_lft, tgt_rght, lft_spd, rght_spd;
  logic [11:0] vbatt;
  int checks = 0;
  int failures = 0;

  mtr_ramp_sched #(.RAMP_DIV(4), .STEP(12'd16), .SPD_LIM(12'd1000), .VBATT_MIN(12'h2C0),
                   .VBATT_OK(12'h300), .LOW_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_lft(tgt_lft), .tgt_rght(tgt_rght), .tgt_vld(tgt_vld),
    .tgt_rdy(tgt_rdy), .go(go), .estop(estop), .vbatt(vbatt), .lft_spd(lft_spd),
    .rght_spd(rght_spd), .busy(busy), .at_tgt(at_tgt), .batt_fault(batt_fault)
  );

  always #5 clk = ~clk;

  task automatic capture(input int l, input int r);
    tgt_lft = 12'(l);
    tgt_rght = 12'(r);
    tgt_vld = 1'b1;
    @(negedge clk);
    tgt_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; go = 1'b0; estop = 1'b0; tgt_vld = 1'b0;
    tgt_lft = '0; tgt_rght = '0; vbatt = 12'h300;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || busy !== 1'b0 || at_tgt !== 1'b0 ||
        batt_fault !== 1'b0 || tgt_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset lft=%0d rght=%0d busy=%b at_tgt=%b bf=%b rdy=%b (want 0 0 0 0 0 1)",
               lft_spd, rght_spd, busy, at_tgt, batt_fault, tgt_rdy);
    end
  endtask

  task automatic test_ramp_up;
    int el[7] = '{16, 32, 48, 64, 80, 96, 100};
    int er[7] = '{-16, -32, -40, -40, -40, -40, -40};
    capture(100, -40);
    go = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || lft_spd !== 12'sd0) begin
      failures++;
      $display("FAIL run_entry busy=%b lft=%0d (want 1 0)", busy, lft_spd);
    end
    for (int k = 0; k < 7; k++) begin
      repeat (3) @(negedge clk);
      checks++;
      if (lft_spd !== 12'(k == 0 ? 0 : el[k-1])) begin
        failures++;
        $display("FAIL ramp_hold k=%0d lft=%0d want=%0d", k, lft_spd, k == 0 ? 0 : el[k-1]);
      end
      @(negedge clk);
      checks++;
      if (lft_spd !== 12'(el[k]) || rght_spd !== 12'(er[k]) || at_tgt !== (k == 6)) begin
        failures++;
        $display("FAIL ramp_up k=%0d lft=%0d rght=%0d at_tgt=%b want %0d %0d %b",
                 k, lft_spd, rght_spd, at_tgt, el[k], er[k], k == 6);
      end
    end
  endtask

  task automatic test_stop;
    int el[7] = '{84, 68, 52, 36, 20, 4, 0};
    int er[7] = '{-24, -8, 0, 0, 0, 0, 0};
    go = 1'b0;
    for (int k = 0; k < 7; k++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (lft_spd !== 12'(el[k]) || rght_spd !== 12'(er[k]) || busy !== 1'b1 || at_tgt !== 1'b0) begin
        failures++;
        $display("FAIL stop_ramp k=%0d lft=%0d rght=%0d busy=%b at_tgt=%b want %0d %0d 1 0",
                 k, lft_spd, rght_spd, busy, at_tgt, el[k], er[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_estop;
    go = 1'b1;
    @(negedge clk);
    repeat (12) @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd48) begin
      failures++;
      $display("FAIL estop_pre lft=%0d want 48", lft_spd);
    end
    estop = 1'b1;
    @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || tgt_rdy !== 1'b0 || batt_fault !== 1'b0 ||
        busy !== 1'b1) begin
      failures++;
      $display("FAIL estop_entry lft=%0d rght=%0d rdy=%b bf=%b busy=%b want 0 0 0 0 1",
               lft_spd, rght_spd, tgt_rdy, batt_fault, busy);
    end
    estop = 1'b0;
    @(negedge clk);
    checks++;
    if (tgt_rdy !== 1'b0) begin
      failures++;
      $display("FAIL estop_hold_go rdy=%b want 0", tgt_rdy);
    end
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tgt_rdy !== 1'b1) begin
      failures++;
      $display("FAIL estop_exit busy=%b rdy=%b want 0 1", busy, tgt_rdy);
    end
  endtask

  task automatic test_battery;
    vbatt = 12'h2BF;
    repeat (7) @(negedge clk);
    vbatt = 12'h300;
    @(negedge clk);
    checks++;
    if (tgt_rdy !== 1'b1 || batt_fault !== 1'b0) begin
      failures++;
      $display("FAIL batt_7low rdy=%b bf=%b want 1 0", tgt_rdy, batt_fault);
    end
    vbatt = 12'h2BF;
    repeat (7) @(negedge clk);
    checks++;
    if (tgt_rdy !== 1'b1) begin
      failures++;
      $display("FAIL batt_early rdy=%b want 1", tgt_rdy);
    end
    @(negedge clk);
    checks++;
    if (batt_fault !== 1'b1 || tgt_rdy !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL batt_trip bf=%b rdy=%b busy=%b want 1 0 1", batt_fault, tgt_rdy, busy);
    end
    vbatt = 12'h2F0;
    repeat (2) @(negedge clk);
    checks++;
    if (batt_fault !== 1'b1 || tgt_rdy !== 1'b0) begin
      failures++;
      $display("FAIL batt_hyst bf=%b rdy=%b want 1 0", batt_fault, tgt_rdy);
    end
    vbatt = 12'h300;
    @(negedge clk);
    checks++;
    if (batt_fault !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL batt_clear bf=%b busy=%b want 0 0", batt_fault, busy);
    end
  endtask

  task automatic test_clamp_retarget;
    capture(2047, -2048);
    go = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd16 || rght_spd !== -12'sd16) begin
      failures++;
      $display("FAIL clamp_step1 lft=%0d rght=%0d want 16 -16", lft_spd, rght_spd);
    end
    repeat (3) @(negedge clk);
    capture(0, 0);
    checks++;
    if (lft_spd !== 12'sd32 || rght_spd !== -12'sd32) begin
      failures++;
      $display("FAIL retarget_tick lft=%0d rght=%0d want 32 -32", lft_spd, rght_spd);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd16 || rght_spd !== -12'sd16) begin
      failures++;
      $display("FAIL retarget_next lft=%0d rght=%0d want 16 -16", lft_spd, rght_spd);
    end
    capture(2047, -2048);
    repeat (255) @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd1000 || rght_spd !== -12'sd1000 || at_tgt !== 1'b1) begin
      failures++;
      $display("FAIL clamp_final lft=%0d rght=%0d at_tgt=%b want 1000 -1000 1",
               lft_spd, rght_spd, at_tgt);
    end
  endtask

  task automatic test_reset_mid_run;
    rst_n = 1'b0; go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    capture(100, -40);
    go = 1'b1;
    @(negedge clk);
    repeat (16) @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd64) begin
      failures++;
      $display("FAIL rst_pre lft=%0d want 64", lft_spd);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || busy !== 1'b0 || at_tgt !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid lft=%0d rght=%0d busy=%b at_tgt=%b want 0 0 0 0",
               lft_spd, rght_spd, busy, at_tgt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || at_tgt !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_held_zero lft=%0d rght=%0d at_tgt=%b busy=%b want 0 0 1 1",
               lft_spd, rght_spd, at_tgt, busy);
    end
    go = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_stop;
    test_estop;
    test_battery;
    test_clamp_retarget;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
